// File: rtl/ct_lsu_dcache_tag_ctrl.sv
// LSU-side controller for the 2-way L1 dcache tag SRAM.
// Arbitrates LSU tag accesses against the invalidate-all sweep.
module ct_lsu_dcache_tag_ctrl #(
    parameter int IDX_W       = 9,
    parameter int WAY_W       = 26,
    parameter int INIT_ON_RST = 1
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 cp0_lsu_dcache_inv_req,
    output logic                 cp0_lsu_dcache_inv_done,
    input  logic                 lsu_req_vld,
    output logic                 lsu_req_ready,
    input  logic                 lsu_req_wr,
    input  logic [IDX_W-1:0]     lsu_req_idx,
    input  logic [1:0]           lsu_req_way_wen,
    input  logic [2*WAY_W-1:0]   lsu_req_din,
    output logic                 lsu_rd_vld,
    output logic [2*WAY_W-1:0]   lsu_rd_data,
    output logic [8:0]           tag_idx,
    output logic [2*WAY_W-1:0]   tag_din,
    output logic                 tag_sel_b,
    output logic                 tag_gwen_b,
    output logic [1:0]           tag_wen_b,
    output logic                 tag_gateclk_en,
    input  logic [2*WAY_W-1:0]   tag_dout
);

    localparam int DW = 2 * WAY_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INV,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_nxt;
    logic               r_init_pend;
    logic               r_rd_p1;
    logic               r_rd_vld;
    logic [DW-1:0]      r_rd_data;

    logic               w_ready;
    logic               w_acc;
    logic               w_rd_en;
    logic               w_wr_en;
    logic [IDX_W-1:0]   w_idx;

    // The sweep wins over any LSU request in the cycle it is requested.
    assign w_ready = (r_state == S_IDLE) & ~cp0_lsu_dcache_inv_req
                   & ~r_init_pend;
    assign w_acc   = lsu_req_vld & w_ready;
    assign w_rd_en = w_acc & ~lsu_req_wr;
    assign w_wr_en = w_acc & lsu_req_wr & (|lsu_req_way_wen);

    // State, sweep counter and post-reset sweep request.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_init_pend <= (INIT_ON_RST != 0);
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_pend <= 1'b0;
        end
    end

    // Next-state logic for the invalidate sweep.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (cp0_lsu_dcache_inv_req | r_init_pend) begin
                    w_state_nxt = S_INV;
                end
            end
            S_INV: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // SRAM control: sweep writes zeros, otherwise pass the accepted access.
    always_comb begin
        tag_sel_b  = 1'b1;
        tag_gwen_b = 1'b1;
        tag_wen_b  = 2'b11;
        tag_din    = '0;
        w_idx      = '0;
        if (r_state == S_INV) begin
            tag_sel_b  = 1'b0;
            tag_gwen_b = 1'b0;
            tag_wen_b  = 2'b00;
            w_idx      = r_cnt;
        end else if (w_wr_en) begin
            tag_sel_b  = 1'b0;
            tag_gwen_b = 1'b0;
            tag_wen_b  = ~lsu_req_way_wen;
            tag_din    = lsu_req_din;
            w_idx      = lsu_req_idx;
        end else if (w_rd_en) begin
            tag_sel_b  = 1'b0;
            w_idx      = lsu_req_idx;
        end
    end

    // Read return pipe: SRAM data is captured one cycle after the access.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_rd_p1   <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_p1  <= w_rd_en;
            r_rd_vld <= r_rd_p1;
            if (r_rd_p1) begin
                r_rd_data <= tag_dout;
            end
        end
    end

    assign tag_idx                 = 9'(w_idx);
    assign tag_gateclk_en          = ~tag_sel_b | r_rd_p1;
    assign lsu_req_ready           = w_ready;
    assign lsu_rd_vld              = r_rd_vld;
    assign lsu_rd_data             = r_rd_data;
    assign cp0_lsu_dcache_inv_done = (r_state == S_DONE);

endmodule

// File: tb/tb_ct_lsu_dcache_tag_ctrl.sv
// Directed bench for ct_lsu_dcache_tag_ctrl with a small tag SRAM model.
// Also runs a 256-set instance through its power-on sweep.
module tb_ct_lsu_dcache_tag_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        inv_req;
    logic        inv_done;
    logic        vld;
    logic        ready;
    logic        wr;
    logic [8:0]  idx;
    logic [1:0]  way_wen;
    logic [51:0] din;
    logic        rd_vld;
    logic [51:0] rd_data;
    logic [8:0]  t_idx;
    logic [51:0] t_din;
    logic        t_sel_b;
    logic        t_gwen_b;
    logic [1:0]  t_wen_b;
    logic        t_gate;
    logic [51:0] t_dout;

    logic        done8;
    logic        ready8;
    logic        rd_vld8;
    logic [51:0] rd_data8;
    logic [8:0]  t_idx8;
    logic [51:0] t_din8;
    logic        t_sel_b8;
    logic        t_gwen_b8;
    logic [1:0]  t_wen_b8;
    logic        t_gate8;

    logic [51:0] mem [512];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ct_lsu_dcache_tag_ctrl #(.IDX_W(9), .WAY_W(26), .INIT_ON_RST(1)) dut (
        .forever_cpuclk          (clk),
        .cpurst                  (cpurst),
        .cp0_lsu_dcache_inv_req  (inv_req),
        .cp0_lsu_dcache_inv_done (inv_done),
        .lsu_req_vld             (vld),
        .lsu_req_ready           (ready),
        .lsu_req_wr              (wr),
        .lsu_req_idx             (idx),
        .lsu_req_way_wen         (way_wen),
        .lsu_req_din             (din),
        .lsu_rd_vld              (rd_vld),
        .lsu_rd_data             (rd_data),
        .tag_idx                 (t_idx),
        .tag_din                 (t_din),
        .tag_sel_b               (t_sel_b),
        .tag_gwen_b              (t_gwen_b),
        .tag_wen_b               (t_wen_b),
        .tag_gateclk_en          (t_gate),
        .tag_dout                (t_dout)
    );

    ct_lsu_dcache_tag_ctrl #(.IDX_W(8), .WAY_W(26), .INIT_ON_RST(1)) dut8 (
        .forever_cpuclk          (clk),
        .cpurst                  (cpurst),
        .cp0_lsu_dcache_inv_req  (1'b0),
        .cp0_lsu_dcache_inv_done (done8),
        .lsu_req_vld             (1'b0),
        .lsu_req_ready           (ready8),
        .lsu_req_wr              (1'b0),
        .lsu_req_idx             (8'h00),
        .lsu_req_way_wen         (2'b00),
        .lsu_req_din             (52'h0),
        .lsu_rd_vld              (rd_vld8),
        .lsu_rd_data             (rd_data8),
        .tag_idx                 (t_idx8),
        .tag_din                 (t_din8),
        .tag_sel_b               (t_sel_b8),
        .tag_gwen_b              (t_gwen_b8),
        .tag_wen_b               (t_wen_b8),
        .tag_gateclk_en          (t_gate8),
        .tag_dout                (52'h0)
    );

    // Tag SRAM: per-way write mask, registered read data.
    always @(posedge clk) begin
        if (!t_sel_b) begin
            if (!t_gwen_b) begin
                if (!t_wen_b[0]) mem[t_idx][25:0]  <= t_din[25:0];
                if (!t_wen_b[1]) mem[t_idx][51:26] <= t_din[51:26];
            end else begin
                t_dout <= mem[t_idx];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [51:0] wd(input int k);
        return {26'h0100000 + 26'(k), 26'h0003000 + 26'(k)};
    endfunction

    // Full 512-entry sweep starting next cycle, then the done pulse.
    task automatic sweep(input int inv_at, input int rd_at,
                         input logic [51:0] rd_d, input bit chk8);
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            inv_req = (i == inv_at);
            vld     = 1'b0;
            #1;
            chk("sweep_ctl",
                {t_sel_b, t_gwen_b, t_wen_b, ready, inv_done, t_idx},
                {4'b0000, 1'b0, 1'b0, 9'(i)});
            chk("sweep_din", t_din, 52'h0);
            if (rd_at >= 0) begin
                chk("sweep_rdvld", rd_vld, (i == rd_at));
                if (i == rd_at) chk("sweep_rddata", rd_data, rd_d);
            end
            if (chk8) begin
                chk("idx8_msb", t_idx8[8], 1'b0);
                if (i < 256) chk("idx8", t_idx8, 9'(i));
                chk("done8", done8, (i == 256));
            end
        end
        inv_req = 1'b0;
        @(negedge clk);
        #1;
        chk("done_pulse", {inv_done, ready, t_sel_b}, 3'b101);
        @(negedge clk);
        #1;
        chk("after_done", {inv_done, ready, t_sel_b}, 3'b011);
    endtask

    initial begin
        cpurst  = 1'b1;
        inv_req = 1'b0;
        vld     = 1'b0;
        wr      = 1'b0;
        idx     = '0;
        way_wen = 2'b00;
        din     = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_sram", {t_sel_b, t_gwen_b, t_wen_b, t_gate}, 5'b11110);
        chk("rst_rd", {rd_vld, inv_done, ready}, 3'b000);
        chk("rst_data", rd_data, 52'h0);

        // Reset release: automatic sweep, both instances
        @(negedge clk);
        cpurst = 1'b0;
        #1;
        chk("rel_ready", ready, 1'b0);
        sweep(-1, -1, 52'h0, 1'b1);

        // Write one way, then read it back
        @(negedge clk);
        vld = 1'b1; wr = 1'b1; idx = 9'h1A5; way_wen = 2'b10;
        din = {26'h2ABCDEF, 26'h1234567};
        #1;
        chk("wr_ctl", {ready, t_sel_b, t_gwen_b, t_wen_b, t_gate}, 6'b100011);
        chk("wr_idx", t_idx, 9'h1A5);
        chk("wr_din", t_din, {26'h2ABCDEF, 26'h1234567});
        @(negedge clk);
        wr = 1'b0;
        #1;
        chk("rd_ctl", {ready, t_sel_b, t_gwen_b, t_wen_b, t_gate}, 6'b101111);
        @(negedge clk);
        vld = 1'b0;
        #1;
        chk("rd_n1", {rd_vld, t_gate}, 2'b01);
        @(negedge clk);
        #1;
        chk("rd_n2_vld", rd_vld, 1'b1);
        chk("rd_n2_data", rd_data, {26'h2ABCDEF, 26'h0000000});

        // Write with no way enabled does nothing
        @(negedge clk);
        vld = 1'b1; wr = 1'b1; way_wen = 2'b00; idx = 9'h1A5;
        din = 52'hF_FFFF_FFFF_FFFF;
        #1;
        chk("wr00", {ready, t_sel_b, t_gwen_b, t_wen_b, t_gate, rd_vld},
            7'b1111100);

        // Fill idx 3..6, then four back-to-back reads
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vld = 1'b1; wr = 1'b1; way_wen = 2'b11;
            idx = 9'(k + 3); din = wd(k + 3);
        end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            vld = (k < 4); wr = 1'b0; idx = 9'(k + 3);
            #1;
            chk("b2b_gate", t_gate, (k <= 4));
            chk("b2b_vld", rd_vld, (k >= 2 && k <= 5));
            if (k >= 2) chk("b2b_data", rd_data, wd((k >= 6) ? 6 : k + 1));
        end

        // In-flight read, then inv_req colliding with a request
        @(negedge clk);
        vld = 1'b1; wr = 1'b0; idx = 9'h1A5;
        @(negedge clk);
        inv_req = 1'b1; vld = 1'b1; idx = 9'h007;
        #1;
        chk("coll_ready", {ready, t_sel_b}, 2'b01);
        sweep(100, 0, {26'h2ABCDEF, 26'h0000000}, 1'b0);
        @(negedge clk);
        #1;
        chk("no_2nd_done", {inv_done, ready}, 2'b01);

        // Reset in the middle of a sweep
        @(negedge clk);
        inv_req = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            inv_req = 1'b0;
        end
        #1;
        chk("pre_rst_idx", t_idx, 9'd100);
        #1;
        cpurst = 1'b1;
        #1;
        chk("mid_rst_sram", {t_sel_b, t_gwen_b, t_wen_b, t_gate}, 5'b11110);
        chk("mid_rst_out", {rd_vld, inv_done, ready}, 3'b000);
        chk("mid_rst_data", rd_data, 52'h0);
        @(negedge clk);
        cpurst = 1'b0;
        #1;
        chk("mid_rel_ready", ready, 1'b0);
        sweep(-1, -1, 52'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
